mul8x8_sequencer: RTL and testbench

Time-multiplexed 8x8 unsigned multiplier controller: accepts one operand pair over a valid/ready handshake, sequences the existing combinational `mult4x4` datapath through four nibble partial products, and accumulates a 16-bit result. It is the scheduling layer above `mult4x4` and lets the design reuse one 4x4 array for wider operands. The result is returned over a valid/ready handshake.

---
 rtl/mul_seq_pkg.sv | 31 +++
 rtl/mult4x4.sv | 20 ++
 rtl/mul8x8_sequencer.sv | 135 +++++++++++++
 tb/tb_mul8x8_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the time-multiplexed 8x8 multiplier.
// Defines the sequencer states, the nibble step encoding and the shift for each step.
package mul_seq_pkg;

    localparam int OPW = 8;
    localparam int PW  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] STEP_LL = 2'd0;
    localparam logic [1:0] STEP_LH = 2'd1;
    localparam logic [1:0] STEP_HL = 2'd2;
    localparam logic [1:0] STEP_HH = 2'd3;

    // Bit weight of the nibble partial product produced in a given step.
    function automatic logic [3:0] step_shift(input logic [1:0] step);
        logic [3:0] shamt;
        case (step)
            STEP_LL: shamt = 4'd0;
            STEP_LH: shamt = 4'd4;
            STEP_HL: shamt = 4'd4;
            default: shamt = 4'd8;
        endcase
        return shamt;
    endfunction

endpackage

// File: rtl/mult4x4.sv
// Combinational 4x4 unsigned array multiplier; the sequencer reuses this one
// instance for every nibble partial product.
module mult4x4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P
);

    always_comb begin
        // NOTE: assigning a default before any conditional update keeps the
        // block purely combinational; a path that leaves P unassigned infers a latch.
        P = '0;
        for (int i = 0; i < 4; i++) begin
            if (B[i]) begin
                P = P + ({4'b0000, A} << i);
            end
        end
    end

endmodule

// File: rtl/mul8x8_sequencer.sv
// 8x8 unsigned multiplier built from four nibble products of one mult4x4,
// with valid/ready handshakes on operands and result.
module mul8x8_sequencer
    import mul_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0]  p,
    output logic          busy
);

    state_e         state_q, state_d;
    logic [1:0]     step_q, step_d;
    logic [OPW-1:0] a_q, a_d;
    logic [OPW-1:0] b_q, b_d;
    logic [PW-1:0]  acc_q, acc_d;

    logic [3:0]     mul_a, mul_b;
    logic [7:0]     mul_p;
    logic [PW-1:0]  pp_shifted;
    logic           accept;

    // Nibble operand selection; the shift is applied in a separate block so
    // no single process reads back its own outputs through the multiplier.
    always_comb begin
        mul_a = a_q[3:0];
        mul_b = b_q[3:0];
        case (step_q)
            STEP_LL: begin
                mul_a = a_q[3:0];
                mul_b = b_q[3:0];
            end
            STEP_LH: begin
                mul_a = a_q[3:0];
                mul_b = b_q[7:4];
            end
            STEP_HL: begin
                mul_a = a_q[7:4];
                mul_b = b_q[3:0];
            end
            default: begin
                mul_a = a_q[7:4];
                mul_b = b_q[7:4];
            end
        endcase
    end

    mult4x4 u_mult4x4 (
        .A(mul_a),
        .B(mul_b),
        .P(mul_p)
    );

    always_comb begin
        pp_shifted = {8'h00, mul_p} << step_shift(step_q);
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;

        case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    step_d  = STEP_LL;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = acc_q + pp_shifted;
                step_d = step_q + 2'd1;
                if (step_q == STEP_HH) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Consuming the result and accepting the next pair share one edge.
                if (out_ready) begin
                    if (in_valid) begin
                        a_d     = a;
                        b_d     = b;
                        acc_d   = '0;
                        step_d  = STEP_LL;
                        state_d = MUL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            step_q  <= STEP_LL;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign p         = acc_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL);

endmodule

// File: tb/tb_mul8x8_sequencer.sv
// Self-checking bench for mul8x8_sequencer: a scoreboard queue of products is
// filled on accepted operands and drained on consumed results.
module tb_mul8x8_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [15:0] sb[$];

    mul8x8_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: sampled mid-cycle, reflecting what the next rising edge does.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_result: got p=%h with no pending operation", p);
                end else begin
                    logic [15:0] exp_p;
                    exp_p = sb.pop_front();
                    if (p !== exp_p) begin
                        failures++;
                        $display("FAIL sb_product: got p=%h expected %h", p, exp_p);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({8'h00, a} * {8'h00, b});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation with out_ready assumed high; returns p seen in DONE.
    task automatic run_op(input logic [7:0] ra, input logic [7:0] rb, output logic [15:0] res);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        a        = ra;
        b        = rb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        guard    = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (!out_valid) begin
            failures++;
            $display("FAIL run_op_timeout: out_valid=%b expected 1 within 20 cycles", out_valid);
        end
        res = p;
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        tick();
        tick();
        checks += 4;
        if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (p !== 16'h0000)      begin failures++; $display("FAIL reset_p: got %h expected 0000", p); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        tick();
        checks += 2;
        if (in_ready !== 1'b1)   begin failures++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_step_trace();
        logic [15:0] trace [4];
        trace[0] = 16'h00E1;
        trace[1] = 16'h0EF1;
        trace[2] = 16'h1D01;
        trace[3] = 16'hFE01;
        out_ready = 1'b1;
        a         = 8'hFF;
        b         = 8'hFF;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        checks += 3;
        if (busy !== 1'b1)      begin failures++; $display("FAIL trace_busy_k: got %b expected 1", busy); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL trace_valid_k: got %b expected 0", out_valid); end
        if (p !== 16'h0000)     begin failures++; $display("FAIL trace_clear_k: got %h expected 0000", p); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 3;
            if (p !== trace[i]) begin
                failures++;
                $display("FAIL trace_acc_%0d: got %h expected %h", i + 1, p, trace[i]);
            end
            if (busy !== (i < 3)) begin
                failures++;
                $display("FAIL trace_busy_%0d: got %b expected %b", i + 1, busy, (i < 3));
            end
            if (out_valid !== (i == 3)) begin
                failures++;
                $display("FAIL trace_valid_%0d: got %b expected %b", i + 1, out_valid, (i == 3));
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL trace_consumed: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_directed();
        logic [15:0] res;
        out_ready = 1'b1;
        run_op(8'h12, 8'h34, res);
        checks++;
        if (res !== 16'h03A8) begin failures++; $display("FAIL directed_12x34: got %h expected 03A8", res); end
        run_op(8'h00, 8'hA5, res);
        checks++;
        if (res !== 16'h0000) begin failures++; $display("FAIL directed_00xA5: got %h expected 0000", res); end
    endtask

    // Streams operands with in_valid and out_ready held high; the scoreboard checks each result.
    task automatic test_sweep();
        int guard;
        out_ready = 1'b1;
        for (int ia = 0; ia < 256; ia++) begin
            for (int jb = 0; jb < 16 + ((ia % 16) == 0 ? 4 : 0); jb++) begin
                a = 8'(ia);
                b = (jb < 16) ? 8'(jb * 17) : 8'($urandom_range(255));
                in_valid = 1'b1;
                guard = 0;
                while (!in_ready && guard < 10) begin
                    tick();
                    guard++;
                end
                if (!in_ready) begin
                    checks++;
                    failures++;
                    $display("FAIL sweep_in_ready_timeout: in_ready=%b expected 1", in_ready);
                end
                tick();
            end
        end
        in_valid = 1'b0;
        guard    = 0;
        while (sb.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sweep_drain: pending=%0d expected 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        int guard;
        out_ready = 1'b0;
        a         = 8'hA5;
        b         = 8'h3C;
        in_valid  = 1'b1;
        tick();
        a     = 8'h11;
        b     = 8'h22;
        guard = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_%0d: got %b expected 0", i, in_ready); end
            tick();
            checks += 2;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid_%0d: got %b expected 1", i, out_valid); end
            if (p !== 16'h26AC)     begin failures++; $display("FAIL bp_hold_p_%0d: got %h expected 26AC", i, p); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release: out_valid=%b expected 0", out_valid); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL bp_no_accept: busy=%b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int guard;
        int first_rise;
        int cyc;
        out_ready = 1'b1;
        a         = 8'h12;
        b         = 8'h34;
        in_valid  = 1'b1;
        tick();
        a   = 8'h56;
        b   = 8'h78;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        first_rise = cyc;
        checks++;
        if (first_rise !== 4) begin failures++; $display("FAIL b2b_first_latency: got %0d expected 4", first_rise); end
        tick();
        in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_consumed: out_valid=%b expected 0", out_valid); end
        if (busy !== 1'b1)      begin failures++; $display("FAIL b2b_restart_busy: got %b expected 1", busy); end
        if (p !== 16'h0000)     begin failures++; $display("FAIL b2b_restart_clear: got %h expected 0000", p); end
        guard = 1;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (guard !== 5) begin failures++; $display("FAIL b2b_period: got %0d cycles expected 5", guard); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] res;
        out_ready = 1'b1;
        a         = 8'h77;
        b         = 8'h99;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        if (p !== 16'h0000)     begin failures++; $display("FAIL rst_mid_p: got %h expected 0000", p); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_stale_%0d: out_valid=%b expected 0", i, out_valid); end
        end
        run_op(8'h03, 8'h05, res);
        checks++;
        if (res !== 16'h000F) begin failures++; $display("FAIL rst_mid_next_op: got %h expected 000F", res); end
    endtask

    initial begin
        test_reset();
        test_step_trace();
        test_directed();
        test_sweep();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        tick();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL final_drain: pending=%0d expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
